// File: rtl/aisoc_mem_pkg.sv
// Shared types and constants for the aisoc memory responder.
package aisoc_mem_pkg;

   localparam int unsigned CNT_W       = 4;
   localparam logic [31:0] ERR_PATTERN = 32'hDEADBEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/aisoc_sram_bytewe.sv
// Word-organised storage: synchronous byte-lane write, asynchronous read.
module aisoc_sram_bytewe #(
   parameter int unsigned WORDS = 1024,
   parameter int unsigned AW    = $clog2(WORDS)
) (
   input  logic          clk_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [WORDS];

   // Contents are deliberately not reset so they survive a core reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (we_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/aisoc_mem_responder.sv
// Wait-state memory responder for a valid/ready core bus.
// Define AISOC_MEM_RESP_ERR_EN to flag out-of-range addresses instead of wrapping.
module aisoc_mem_responder
   import aisoc_mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        bus_err
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       wstrb_q, wstrb_d;
   logic             ready_q, ready_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic [31:0]      sram_rdata;
   logic [3:0]       sram_we_c;
   logic             out_of_range_c;
   logic             unused_c;

   assign unused_c = ^{mem_instr, addr_q};

`ifdef AISOC_MEM_RESP_ERR_EN
   assign out_of_range_c = (addr_q >> (AW + 2)) != 32'd0;
`else
   assign out_of_range_c = 1'b0;
`endif

   aisoc_sram_bytewe #(
      .WORDS (MEM_WORDS),
      .AW    (AW)
   ) u_sram (
      .clk_i   (clk),
      .we_i    (sram_we_c),
      .addr_i  (addr_q[AW+1:2]),
      .wdata_i (wdata_q),
      .rdata_o (sram_rdata)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Response outputs are computed on the WAIT->RESP transition so they are registered during RESP.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      ready_d   = 1'b0;
      rdata_d   = '0;
      err_d     = 1'b0;
      sram_we_c = 4'b0000;

      unique case (state_q)
         ST_IDLE: begin
            if (mem_valid) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!mem_valid) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_RESP;
               ready_d = 1'b1;
               err_d   = out_of_range_c;
               if (out_of_range_c) begin
                  rdata_d = ERR_PATTERN;
               end else if (wstrb_q == 4'b0000) begin
                  rdata_d = sram_rdata;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (!out_of_range_c) begin
               sram_we_c = wstrb_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign mem_ready = ready_q;
   assign mem_rdata = rdata_q;
   assign bus_err   = err_q;

endmodule
